// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared types and constants for the operand entry front end
package operand_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } entry_state_t;

    // 10 ms of stability at a 100 MHz system clock
    localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/debounce_one_shot.sv
// rtl/debounce_one_shot.sv - button synchronizer, debouncer and rising-edge one-shot
module debounce_one_shot
    import operand_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            s1_q         <= btn;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            // Only the accepted rising edge matters; release is ignored.
            press_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - drives operand bus and A/B load strobes from debounced button presses
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned W               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn,
    input  logic [W-1:0] sw,
    output logic [W-1:0] d,
    output logic         en_a,
    output logic         en_b,
    output logic [1:0]   state,
    output logic         ready
);

    logic         press;
    logic [W-1:0] d_q;
    entry_state_t state_q, state_d;

    debounce_one_shot #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    always_comb begin
        state_d = state_q;
        en_a    = press & ((state_q == LOAD_A) | (state_q == FULL));
        en_b    = press & (state_q == LOAD_B);
        case (state_q)
            LOAD_A:  if (press) state_d = LOAD_B;
            LOAD_B:  if (press) state_d = FULL;
            // Wrap: a fresh A invalidates the old B.
            FULL:    if (press) state_d = LOAD_B;
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= sw;
        end
    end

    assign d     = d_q;
    assign state = state_q;
    assign ready = (state_q == FULL);

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - self-checking bench for operand_loader
module tb_operand_loader;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] sw  = 4'h0;
    logic [3:0] d;
    logic       en_a, en_b, ready;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic [3:0] dv;
    } strobe_t;

    typedef struct {
        logic [3:0] sw;
        logic       exp_a;
        logic       exp_b;
        logic [1:0] exp_state;
        logic       exp_ready;
    } vec_t;

    strobe_t exp_q[$];
    vec_t    tbl[5];

    operand_loader #(.W(4), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .sw   (sw),
        .d    (d),
        .en_a (en_a),
        .en_b (en_b),
        .state(state),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && (en_a || en_b)) begin
            check("strobe_exclusive", int'(en_a && en_b), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                strobe_t e;
                e = exp_q.pop_front();
                check("sb_en_a", int'(en_a), int'(e.a));
                check("sb_en_b", int'(en_b), int'(e.b));
                check("sb_d", int'(d), int'(e.dv));
            end
        end
    end

    // Caller has just made btn high at a negedge; the next posedge is edge k.
    task automatic wait_strobe(input string name, input int exp_n);
        bit seen = 1'b0;
        int n    = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (en_a || en_b) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check({name, "_seen"}, int'(seen), 1);
        check({name, "_latency"}, n, exp_n);
        @(posedge clk);
        @(negedge clk);
        check({name, "_width"}, int'(en_a || en_b), 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_press(input logic [3:0] v, input logic a, input logic b, input string name);
        sw = v;
        cycles(2);
        exp_q.push_back('{a: a, b: b, dv: v});
        btn = 1'b1;
        wait_strobe(name, DEB + 2);
        cycles(3);
        btn = 1'b0;
        cycles(2 * DEB + 6);
    endtask

    initial begin
        tbl[0] = '{sw: 4'h3, exp_a: 1'b1, exp_b: 1'b0, exp_state: 2'd1, exp_ready: 1'b0};
        tbl[1] = '{sw: 4'hC, exp_a: 1'b0, exp_b: 1'b1, exp_state: 2'd2, exp_ready: 1'b1};
        tbl[2] = '{sw: 4'h5, exp_a: 1'b1, exp_b: 1'b0, exp_state: 2'd1, exp_ready: 1'b0};
        tbl[3] = '{sw: 4'h9, exp_a: 1'b0, exp_b: 1'b1, exp_state: 2'd2, exp_ready: 1'b1};
        tbl[4] = '{sw: 4'h6, exp_a: 1'b1, exp_b: 1'b0, exp_state: 2'd1, exp_ready: 1'b0};

        cycles(3);
        check("rst_state", int'(state), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_d", int'(d), 0);
        rst = 1'b0;

        // Idle: d follows sw one clock later, nothing else moves.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] v;
            v  = 4'($urandom_range(0, 15));
            sw = v;
            @(negedge clk);
            check("idle_d", int'(d), int'(v));
            check("idle_state", int'(state), 0);
            check("idle_ready", int'(ready), 0);
        end

        // Bounce: 2-clock pulses must be rejected, then one strobe after the final rise.
        sw = 4'hA;
        exp_q.push_back('{a: 1'b1, b: 1'b0, dv: 4'hA});
        for (int i = 0; i < 2; i++) begin
            btn = 1'b1; cycles(2);
            btn = 1'b0; cycles(2);
        end
        check("bounce_no_strobe", exp_q.size(), 1);
        btn = 1'b1;
        wait_strobe("bounce", DEB + 2);
        @(negedge clk);
        check("bounce_state", int'(state), 1);
        btn = 1'b0;
        cycles(2 * DEB + 6);
        check("release_no_strobe", exp_q.size(), 0);

        // Return to LOAD_A via reset so the table starts from a known state.
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);

        for (int i = 0; i < 5; i++) begin
            do_press(tbl[i].sw, tbl[i].exp_a, tbl[i].exp_b, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].exp_state));
            check($sformatf("vec%0d_ready", i), int'(ready), int'(tbl[i].exp_ready));
        end

        // Reset mid-debounce with button still held through release.
        sw  = 4'h7;
        btn = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(2);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_ready", int'(ready), 0);
        check("mid_rst_d", int'(d), 0);
        check("mid_rst_en", int'(en_a || en_b), 0);
        exp_q.push_back('{a: 1'b1, b: 1'b0, dv: 4'h7});
        rst = 1'b0;
        wait_strobe("post_rst", DEB + 2);
        @(negedge clk);
        check("post_rst_state", int'(state), 1);
        btn = 1'b0;
        cycles(2 * DEB + 6);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
